// File: rtl/pfb_pkg.sv
// Purpose: shared types and defaults for pattern_flag_bank (FSM states, compare-mode codes, parameter defaults).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package pfb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } pfb_state_e;

  localparam logic MODE_TRUE = 1'b0;  // match data against pattern as stored
  localparam logic MODE_INV  = 1'b1;  // match data against bitwise-inverted pattern

  localparam int PFB_NCH_DEF = 4;
  localparam int PFB_PW_DEF  = 7;
  localparam int PFB_CW_DEF  = 4;

endpackage

// File: rtl/pfb_channel.sv
// Purpose: one channel of the bank: pattern match, toggle flag, pending bit, optional saturating hit counter (PFB_EVENT_COUNT_EN).
// Latency: flag/pend/cnt update one edge after a combinational hit.
// Backpressure: pend holds until the top-level handshake clears it; a same-cycle hit re-sets it.
module pfb_channel
  import pfb_pkg::*;
#(
  parameter int PW = PFB_PW_DEF,
  parameter int CW = PFB_CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic          gate_i,
  input  logic [PW-1:0] data_i,
  input  logic [PW-1:0] pat_i,
  input  logic          clr_i,
  output logic          flag_o,
  output logic          pend_o,
  output logic [CW-1:0] cnt_o
);

  logic [PW-1:0] ref_pat;
  logic          hit;
  logic          flag_d, flag_q;
  logic          pend_d, pend_q;

  // Match against the (optionally inverted) pattern; a hit toggles the flag and sets pend, set beating clear.
  always_comb begin
    ref_pat = (mode == MODE_INV) ? ~pat_i : pat_i;
    hit     = en & gate_i & (data_i == ref_pat);
    flag_d  = flag_q ^ hit;
    pend_d  = hit | (pend_q & ~clr_i);
  end

  // Flag and pending state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
      pend_q <= pend_d;
    end
  end

  assign flag_o = flag_q;
  assign pend_o = pend_q;

`ifdef PFB_EVENT_COUNT_EN
  logic [CW-1:0] cnt_d, cnt_q;

  // Saturating hit counter: stops at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (hit && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/pattern_flag_bank.sv
// Purpose: NCH-channel pattern matcher with toggle flags and a round-robin valid/ready event port; counters via PFB_EVENT_COUNT_EN.
// Latency: flag 1 edge after hit; event valid at earliest 2 edges after hit; every event occupies >= 2 cycles.
// Backpressure: evt_ch_o holds while evt_valid_o & ~evt_ready_i; pending hits wait in per-channel pend bits.
module pattern_flag_bank
  import pfb_pkg::*;
#(
  parameter int NCH = PFB_NCH_DEF,
  parameter int PW  = PFB_PW_DEF,
  parameter int CW  = PFB_CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     cfg_we,
  input  logic [PW-1:0]            pat_cfg,
  input  logic [NCH*PW-1:0]        data_i,
  input  logic [NCH-1:0]           gate_i,
  output logic [NCH-1:0]           flag_o,
  output logic                     evt_valid_o,
  output logic [$clog2(NCH)-1:0]   evt_ch_o,
  input  logic                     evt_ready_i,
  output logic [NCH*CW-1:0]        cnt_o
);

  localparam int IW = $clog2(NCH);

  logic [PW-1:0]  pat_d, pat_q;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] clr;
  logic           hs;
  logic           gnt_vld;
  logic [IW-1:0]  gnt_ch;
  int             idx;
  pfb_state_e     state_d, state_q;
  logic [IW-1:0]  evt_ch_d, evt_ch_q;
  logic [IW-1:0]  rr_ptr_d, rr_ptr_q;

  // Pattern load is independent of en; compares this cycle still see the old value.
  always_comb begin
    pat_d = cfg_we ? pat_cfg : pat_q;
  end

  // Round-robin pick: scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = IW'(idx);
      end
    end
  end

  // Handshake FSM next state; the accept edge clears the granted pend bit and advances rr_ptr.
  always_comb begin
    state_d  = state_q;
    evt_ch_d = evt_ch_q;
    rr_ptr_d = rr_ptr_q;
    hs       = 1'b0;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d  = PRESENT;
          evt_ch_d = gnt_ch;
        end
      end
      PRESENT: begin
        if (evt_ready_i) begin
          hs            = 1'b1;
          clr[evt_ch_q] = 1'b1;
          state_d       = IDLE;
          rr_ptr_d      = (evt_ch_q == IW'(NCH - 1)) ? '0 : evt_ch_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern, FSM state and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q    <= '0;
      state_q  <= IDLE;
      evt_ch_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      pat_q    <= pat_d;
      state_q  <= state_d;
      evt_ch_q <= evt_ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign evt_valid_o = (state_q == PRESENT);
  assign evt_ch_o    = evt_ch_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pfb_channel #(
      .PW (PW),
      .CW (CW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .gate_i (gate_i[k]),
      .data_i (data_i[k*PW +: PW]),
      .pat_i  (pat_q),
      .clr_i  (clr[k]),
      .flag_o (flag_o[k]),
      .pend_o (pend[k]),
      .cnt_o  (cnt_o[k*CW +: CW])
    );
  end

endmodule

// File: doc/pattern_flag_bank.md
PATTERN_FLAG_BANK -- requirements
Module: pattern_flag_bank

Interface
REQ-001 Parameter NCH, default 4, number of channels (2..16).
REQ-002 Parameter PW, default 7, pattern width per channel.
REQ-003 Parameter CW, default 4, event-counter width per channel.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  global update enable; when low, all state holds.
REQ-007 mode  in  1  0 = match pattern true, 1 = match pattern inverted.
REQ-008 cfg_we  in  1  load strobe for pat_cfg.
REQ-009 pat_cfg  in  PW  compare pattern value.
REQ-010 data_i  in  NCH*PW  per-channel data; channel k occupies bits [k*PW +: PW].
REQ-011 gate_i  in  NCH  per-channel qualifier.
REQ-012 flag_o  out  NCH  per-channel toggle flag.
REQ-013 evt_valid_o  out  1  event available.
REQ-014 evt_ch_o  out  clog2(NCH)  channel index of the presented event.
REQ-015 evt_ready_i  in  1  consumer accepts the event.
REQ-016 cnt_o  out  NCH*CW  per-channel saturating hit counts.

Function
REQ-017 pat_q SHALL load pat_cfg on the edge where cfg_we=1, independent of en; a compare in that same cycle SHALL use the old pat_q.
REQ-018 match[k] SHALL be (data_k == pat_q) when mode=0 and (data_k == ~pat_q) when mode=1.
REQ-019 hit[k] SHALL be en & gate_i[k] & match[k], evaluated combinationally.
REQ-020 On hit[k], flag_o[k] SHALL invert at the next edge (1-cycle latency); otherwise it SHALL hold.
REQ-021 On hit[k], pend[k] SHALL set at the next edge.
REQ-022 The handshake FSM SHALL have two states: IDLE and PRESENT.
REQ-023 In IDLE with any pend bit set, the FSM SHALL grant the first set pend bit at or after rr_ptr (round-robin, wrapping from NCH-1 to 0), drive evt_ch_o, and enter PRESENT; evt_valid_o SHALL be 1 exactly in PRESENT.
REQ-024 In PRESENT, evt_ch_o SHALL stay stable until evt_valid_o & evt_ready_i; on that edge pend[granted] SHALL clear, rr_ptr SHALL become granted+1 mod NCH, and the FSM SHALL return to IDLE.
REQ-025 A hit on the granted channel in the same cycle as its handshake SHALL leave pend set (the set wins).
REQ-026 evt_ready_i in IDLE SHALL be ignored; each event SHALL take at least 2 cycles (no back-to-back valid).
REQ-027 cnt[k] SHALL increment on hit[k] and saturate at 2^CW-1 without wrapping.
REQ-028 With en=0, flag, pend, and cnt SHALL hold; the handshake FSM SHALL continue draining pending events.

Reset
REQ-029 On rst=1 at an edge, the block SHALL set pat_q=0, flag_o=0, pend=0, cnt=0, rr_ptr=0, FSM=IDLE, evt_valid_o=0, and evt_ch_o=0.
REQ-030 A reset during PRESENT SHALL drop evt_valid_o at that edge; the event SHALL be lost.
REQ-031 rst SHALL take priority over cfg_we, hits, and the handshake.

Configuration
REQ-032 Macro PFB_EVENT_COUNT_EN SHALL control the counter feature.
- Defined: the counters exist and behave per REQ-027.
- Undefined: no counter registers; cnt_o stays in the port list, tied to 0.

Structure
REQ-033 Package pfb_pkg SHALL hold the FSM state enum (IDLE, PRESENT), the mode encoding constants, and the default parameter values.
REQ-034 Sub-module pfb_channel SHALL hold the per-channel match, flag, pend, and counter logic, instantiated NCH times; the arbiter and FSM SHALL sit at the top level.

Verification
REQ-035 Reset, then cfg_we with pat_cfg=7'h55, mode=0, en=1, gate_i=4'b0001, data ch0=7'h55 for 1 cycle -> flag_o=4'b0001 next cycle; evt_valid_o=1 with evt_ch_o=0 one cycle later.
REQ-036 mode=1, pat_q=7'h55, data ch2=7'h2A, gate_i[2]=1 -> flag_o[2] toggles; same data with en=0 -> no change.
REQ-037 Hits on ch1 and ch3 in the same cycle, rr_ptr=2, evt_ready_i=1 held -> events ch3 then ch1, each valid for 1 cycle with an IDLE cycle between.
REQ-038 Hit ch0 held for 20 cycles with CW=4 and the macro defined -> cnt_o[ch0]=15 held; macro undefined -> cnt_o=0.
REQ-039 evt_ready_i=0 in PRESENT for 5 cycles -> evt_ch_o stable; rst asserted in cycle 3 -> evt_valid_o=0 and pend=0 after that edge.
REQ-040 cfg_we and a matching hit against the old pat_q in the same cycle -> hit counted; the next cycle compares against the new pat_q.
